// File: rtl/flag_branch_if.sv
// Interface bundle for flag_branch_unit.
// Carries the ALU status flags, the branch request and control, and the resolution results.
interface flag_branch_if #(
  parameter int CNT_W = 16
);
  logic             alu_negative;
  logic             alu_zero;
  logic             alu_overflow;
  logic             alu_carry;
  logic             set_flags;
  logic             br_req;
  logic [1:0]       br_type;
  logic [3:0]       cond;
  logic             stall;
  logic             flush;
  logic [3:0]       flags_q;
  logic             br_valid;
  logic             br_taken;
  logic             fwd_hit;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output alu_negative, alu_zero, alu_overflow, alu_carry,
    output set_flags, br_req, br_type, cond, stall, flush,
    input  flags_q, br_valid, br_taken, fwd_hit, taken_count
  );

  modport slave (
    input  alu_negative, alu_zero, alu_overflow, alu_carry,
    input  set_flags, br_req, br_type, cond, stall, flush,
    output flags_q, br_valid, br_taken, fwd_hit, taken_count
  );
endinterface

// File: rtl/flag_branch_unit.sv
// flag_branch_unit: architectural NZVC register plus LEGv8 branch resolver.
// B.cond resolves on forwarded ALU flags when the same cycle sets them; otherwise it
// uses the stored flags. CBZ/CBNZ test the live ALU zero result directly.
module flag_branch_unit #(
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          reset,
  flag_branch_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0]       flags_r;
  logic             valid_r;
  logic             taken_r;
  logic             fwd_r;
  logic [CNT_W-1:0] cnt_r;

  logic [3:0] live;
  logic [3:0] eff;
  logic       n, z, v, c;
  logic       cond_true;
  logic       taken;
  logic       accept;

  assign live = {bus.alu_negative, bus.alu_zero, bus.alu_overflow, bus.alu_carry};

  // Select effective flags and evaluate the branch condition.
  always_comb begin
    eff = bus.set_flags ? live : flags_r;
    {n, z, v, c} = eff;
    cond_true = 1'b0;
    case (bus.cond)
      4'b0000: cond_true = z;
      4'b0001: cond_true = !z;
      4'b0010: cond_true = c;
      4'b0011: cond_true = !c;
      4'b0100: cond_true = n;
      4'b0101: cond_true = !n;
      4'b0110: cond_true = v;
      4'b0111: cond_true = !v;
      4'b1000: cond_true = c & !z;
      4'b1001: cond_true = !c | z;
      4'b1010: cond_true = (n == v);
      4'b1011: cond_true = (n != v);
      4'b1100: cond_true = !z & (n == v);
      4'b1101: cond_true = z | (n != v);
      default: cond_true = 1'b1;
    endcase
  end

  // Decide taken per branch type; stall beats flush, flush beats the request.
  always_comb begin
    taken = 1'b0;
    case (bus.br_type)
      2'b00:   taken = cond_true;
      2'b01:   taken = bus.alu_zero;
      2'b10:   taken = !bus.alu_zero;
      default: taken = 1'b0;
    endcase
    accept = bus.br_req & !bus.stall & !bus.flush;
  end

  // Flag register, one-cycle resolution outputs and saturating taken counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_r <= 4'b0000;
      valid_r <= 1'b0;
      taken_r <= 1'b0;
      fwd_r   <= 1'b0;
      cnt_r   <= '0;
    end else begin
      if (bus.set_flags && !bus.stall) flags_r <= live;
      valid_r <= accept;
      taken_r <= accept & taken;
      fwd_r   <= accept & bus.set_flags & (bus.br_type == 2'b00);
      if (accept && taken && (cnt_r != CNT_MAX)) cnt_r <= cnt_r + CNT_ONE;
    end
  end

  assign bus.flags_q     = flags_r;
  assign bus.br_valid    = valid_r;
  assign bus.br_taken    = taken_r;
  assign bus.fwd_hit     = fwd_r;
  assign bus.taken_count = cnt_r;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Testbench for flag_branch_unit: directed scenarios followed by random traffic,
// all checked against a behavioural model of the flag/branch rules.
module tb_flag_branch_unit;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  flag_branch_if #(.CNT_W(CW)) bus ();

  flag_branch_unit #(.CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // model state
  logic [3:0] m_flags;
  logic       m_valid, m_taken, m_fwd;
  int         m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Condition semantics: pairs of codes share a base test; odd code negates it.
  function automatic logic cond_holds(input logic [3:0] cd, input logic [3:0] f);
    logic fn, fz, fv, fc, r;
    {fn, fz, fv, fc} = f;
    case (int'(cd) / 2)
      0: r = fz;
      1: r = fc;
      2: r = fn;
      3: r = fv;
      4: r = fc && !fz;
      5: r = (fn == fv);
      6: r = !fz && (fn == fv);
      default: return 1'b1;
    endcase
    return (cd % 2 == 1) ? !r : r;
  endfunction

  task automatic drive(input logic [3:0] f, input logic sf, input logic br,
                       input logic [1:0] bt, input logic [3:0] cd,
                       input logic st, input logic fl);
    {bus.alu_negative, bus.alu_zero, bus.alu_overflow, bus.alu_carry} = f;
    bus.set_flags = sf;
    bus.br_req    = br;
    bus.br_type   = bt;
    bus.cond      = cd;
    bus.stall     = st;
    bus.flush     = fl;
  endtask

  task automatic model_reset();
    m_flags = 4'b0000; m_valid = 0; m_taken = 0; m_fwd = 0; m_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".flags_q"},     32'(bus.flags_q),     32'(m_flags));
    check({tag, ".br_valid"},    32'(bus.br_valid),    32'(m_valid));
    check({tag, ".br_taken"},    32'(bus.br_taken),    32'(m_taken));
    check({tag, ".fwd_hit"},     32'(bus.fwd_hit),     32'(m_fwd));
    check({tag, ".taken_count"}, 32'(bus.taken_count), 32'(m_cnt));
  endtask

  // One clock: predict from pre-edge inputs, advance, compare.
  task automatic step(input string tag);
    logic [3:0] live, eff, nflags;
    logic acc, tk, nv, nt, nf;
    int ncnt;
    live = {bus.alu_negative, bus.alu_zero, bus.alu_overflow, bus.alu_carry};
    eff  = bus.set_flags ? live : m_flags;
    acc  = bus.br_req && !bus.stall && !bus.flush;
    if (bus.br_type == 2'd0)      tk = cond_holds(bus.cond, eff);
    else if (bus.br_type == 2'd1) tk = bus.alu_zero;
    else if (bus.br_type == 2'd2) tk = !bus.alu_zero;
    else                          tk = 1'b0;
    nflags = (bus.set_flags && !bus.stall) ? live : m_flags;
    nv = acc;
    nt = acc && tk;
    nf = acc && bus.set_flags && (bus.br_type == 2'd0);
    ncnt = (nt && m_cnt < (1 << CW) - 1) ? m_cnt + 1 : m_cnt;
    @(posedge clk);
    #1;
    m_flags = nflags; m_valid = nv; m_taken = nt; m_fwd = nf; m_cnt = ncnt;
    check_all(tag);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    model_reset();
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    drive(4'b0000, 0, 0, 2'd0, 4'd0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_all("reset_hold");
    reset = 1'b0;

    // 1: SUBS N0 Z1 V0 C1 then idle
    drive(4'b0101, 1, 0, 2'd0, 4'd0, 0, 0);
    step("t1_capture");
    check("t1_flags", 32'(bus.flags_q), 32'h5);
    drive(4'b1010, 0, 0, 2'd0, 4'd0, 0, 0);
    for (int i = 0; i < 5; i++) step("t1_idle");
    check("t1_flags_held", 32'(bus.flags_q), 32'h5);

    // 2: same-cycle forward for B.EQ
    pulse_reset();
    drive(4'b0100, 1, 1, 2'd0, 4'b0000, 0, 0);
    step("t2_fwd");
    check("t2_valid", 32'(bus.br_valid), 32'd1);
    check("t2_taken", 32'(bus.br_taken), 32'd1);
    check("t2_fwd",   32'(bus.fwd_hit),  32'd1);
    check("t2_flags", 32'(bus.flags_q),  32'h4);
    drive(4'b0000, 0, 0, 2'd0, 4'd0, 0, 0);
    step("t2_pulse_end");
    check("t2_valid_pulse", 32'(bus.br_valid), 32'd0);

    // 3: flags 1000, signed conditions from stored flags (live flags are decoys)
    drive(4'b1000, 1, 0, 2'd0, 4'd0, 0, 0);
    step("t3_set");
    drive(4'b0111, 0, 1, 2'd0, 4'b1011, 0, 0); step("t3_lt");
    check("t3_lt_taken", 32'(bus.br_taken), 32'd1);
    drive(4'b0111, 0, 1, 2'd0, 4'b1010, 0, 0); step("t3_ge");
    check("t3_ge_taken", 32'(bus.br_taken), 32'd0);
    drive(4'b0111, 0, 1, 2'd0, 4'b1100, 0, 0); step("t3_gt");
    check("t3_gt_taken", 32'(bus.br_taken), 32'd0);
    drive(4'b0111, 0, 1, 2'd0, 4'b1111, 0, 0); step("t3_nv");
    check("t3_nv_taken", 32'(bus.br_taken), 32'd1);

    // 4: CBZ / CBNZ on live zero, flags untouched
    drive(4'b0100, 0, 1, 2'd1, 4'b0001, 0, 0); step("t4_cbz");
    check("t4_cbz_taken", 32'(bus.br_taken), 32'd1);
    drive(4'b0000, 0, 1, 2'd2, 4'b0000, 0, 0); step("t4_cbnz");
    check("t4_cbnz_taken", 32'(bus.br_taken), 32'd1);
    check("t4_flags", 32'(bus.flags_q), 32'h8);
    drive(4'b0100, 0, 1, 2'd3, 4'b1110, 0, 0); step("t4_reserved");
    check("t4_rsv_valid", 32'(bus.br_valid), 32'd1);
    check("t4_rsv_taken", 32'(bus.br_taken), 32'd0);

    // 5: flush drops request but still captures; stall holds everything
    drive(4'b0011, 1, 1, 2'd0, 4'b1110, 0, 1); step("t5_flush");
    check("t5_flush_valid", 32'(bus.br_valid), 32'd0);
    check("t5_flush_flags", 32'(bus.flags_q), 32'h3);
    drive(4'b1111, 1, 1, 2'd0, 4'b1110, 1, 1); step("t5_stall");
    check("t5_stall_valid", 32'(bus.br_valid), 32'd0);
    check("t5_stall_flags", 32'(bus.flags_q), 32'h3);
    check("t5_stall_cnt", 32'(bus.taken_count), 32'd5);

    // 6: saturation then asynchronous reset mid-stream
    drive(4'b0000, 0, 1, 2'd0, 4'b1110, 0, 0);
    for (int i = 0; i < 17; i++) step("t6_sat");
    check("t6_cnt_sat", 32'(bus.taken_count), 32'd15);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("t6_async_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    check_all("t6_reset_release");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(4'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
            2'($urandom), 4'($urandom),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
